// File: rtl/ring_counter_if.sv
// rtl/ring_counter_if.sv - observation bundle for the ring_counter pattern, index and status flags
interface ring_counter_if #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
);
    logic [WIDTH-1:0] count;
    logic [PW-1:0]    pos;
    logic             tc;
    logic             err;

    modport master (output count, output pos, output tc, output err);
    modport slave  (input  count, input  pos, input  tc, input  err);
endinterface

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - free-running one-hot / Johnson ring counter with index, terminal count and error flag
// Optional build macro: RING_COUNTER_SELF_CORRECT_EN (reload reset pattern when an illegal pattern is seen)
module ring_counter #(
    parameter int  WIDTH       = 4,
    parameter int  JOHNSON     = 0,
    parameter int  ROTATE_LEFT = 1,
    localparam int PW          = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    pos,
    output logic             tc,
    output logic             err
);
    localparam int               N         = (JOHNSON != 0) ? 2 * WIDTH : WIDTH;
    localparam logic [PW-1:0]    LAST      = PW'(N - 1);
    localparam logic [WIDTH-1:0] RESET_PAT = (JOHNSON != 0) ? '0 : WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d, shifted, inv;
    logic [PW-1:0]    pos_q, pos_d, pos_inc;
    logic             feedback, legal;

    always_comb begin
        feedback = 1'b0;
        shifted  = count_q;
        if (ROTATE_LEFT != 0) begin
            feedback = (JOHNSON != 0) ? ~count_q[WIDTH-1] : count_q[WIDTH-1];
            shifted  = {count_q[WIDTH-2:0], feedback};
        end else begin
            feedback = (JOHNSON != 0) ? ~count_q[0] : count_q[0];
            shifted  = {feedback, count_q[WIDTH-1:1]};
        end
    end

    // Johnson legal set is a thermometer of ones anchored at either the LSB or the MSB.
    always_comb begin
        inv = ~count_q;
        if (JOHNSON != 0) begin
            legal = ((count_q & (count_q + WIDTH'(1))) == '0) ||
                    ((inv & (inv + WIDTH'(1))) == '0);
        end else begin
            legal = (count_q != '0) && ((count_q & (count_q - WIDTH'(1))) == '0);
        end
    end

    assign pos_inc = (pos_q == LAST) ? '0 : pos_q + PW'(1);

    always_comb begin
        count_d = shifted;
        pos_d   = pos_inc;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        if (!legal) begin
            count_d = RESET_PAT;
            pos_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_PAT;
            pos_q   <= '0;
        end else begin
            count_q <= count_d;
            pos_q   <= pos_d;
        end
    end

    assign count = count_q;
    assign pos   = pos_q;
    assign tc    = (pos_q == LAST);
    assign err   = ~legal;
endmodule

// File: tb/tb_ring_counter.sv
// tb/tb_ring_counter.sv - scoreboard bench for ring_counter in ring, Johnson, rotate-right and WIDTH=8 builds
module tb_ring_counter;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #10 clk = ~clk;

    ring_counter_if #(.WIDTH(4), .PW(3)) if_def ();
    ring_counter_if #(.WIDTH(4), .PW(3)) if_joh ();
    ring_counter_if #(.WIDTH(4), .PW(3)) if_rr ();
    ring_counter_if #(.WIDTH(8), .PW(4)) if_w8 ();

    ring_counter #(.WIDTH(4), .JOHNSON(0), .ROTATE_LEFT(1)) u_def (
        .clk(clk), .reset(reset), .count(if_def.count), .pos(if_def.pos), .tc(if_def.tc), .err(if_def.err));
    ring_counter #(.WIDTH(4), .JOHNSON(1), .ROTATE_LEFT(1)) u_joh (
        .clk(clk), .reset(reset), .count(if_joh.count), .pos(if_joh.pos), .tc(if_joh.tc), .err(if_joh.err));
    ring_counter #(.WIDTH(4), .JOHNSON(0), .ROTATE_LEFT(0)) u_rr (
        .clk(clk), .reset(reset), .count(if_rr.count), .pos(if_rr.pos), .tc(if_rr.tc), .err(if_rr.err));
    ring_counter #(.WIDTH(8), .JOHNSON(0), .ROTATE_LEFT(1)) u_w8 (
        .clk(clk), .reset(reset), .count(if_w8.count), .pos(if_w8.pos), .tc(if_w8.tc), .err(if_w8.err));

    logic [31:0] obs_cnt [4];
    logic [31:0] obs_pos [4];
    logic        obs_tc  [4];
    logic        obs_err [4];

    always_comb begin
        obs_cnt[0] = 32'(if_def.count); obs_pos[0] = 32'(if_def.pos); obs_tc[0] = if_def.tc; obs_err[0] = if_def.err;
        obs_cnt[1] = 32'(if_joh.count); obs_pos[1] = 32'(if_joh.pos); obs_tc[1] = if_joh.tc; obs_err[1] = if_joh.err;
        obs_cnt[2] = 32'(if_rr.count);  obs_pos[2] = 32'(if_rr.pos);  obs_tc[2] = if_rr.tc;  obs_err[2] = if_rr.err;
        obs_cnt[3] = 32'(if_w8.count);  obs_pos[3] = 32'(if_w8.pos);  obs_tc[3] = if_w8.tc;  obs_err[3] = if_w8.err;
    end

    typedef struct packed {
        logic [3:0][31:0] cnt;
        logic [3:0][31:0] pos;
        logic [3:0]       tc;
    } exp_t;

    exp_t sb_q[$];
    int   idx [4];
    int   errors    = 0;
    int   checks    = 0;
    int   tc_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unit_w(input int u);
        return (u == 3) ? 8 : 4;
    endfunction

    function automatic int unit_n(input int u);
        return (u == 1) ? 8 : unit_w(u);
    endfunction

    // Closed-form pattern for state i of each unit (0 default, 1 Johnson, 2 rotate right, 3 WIDTH=8).
    function automatic logic [31:0] exp_pat(input int u, input int i);
        int          w;
        logic [31:0] mask;
        w    = unit_w(u);
        mask = (32'd1 << w) - 32'd1;
        case (u)
            1:       return (i <= w) ? ((32'd1 << i) - 32'd1) : ((mask << (i - w)) & mask);
            2:       return (i == 0) ? 32'd1 : (32'd1 << (w - i));
            default: return 32'd1 << i;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("%s_cnt%0d", tag, u), obs_cnt[u], exp_pat(u, 0));
            check($sformatf("%s_pos%0d", tag, u), obs_pos[u], 32'd0);
            check($sformatf("%s_err%0d", tag, u), 32'(obs_err[u]), 32'd0);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        for (int u = 0; u < 4; u++) begin
            idx[u]   = (idx[u] + 1) % unit_n(u);
            e.cnt[u] = exp_pat(u, idx[u]);
            e.pos[u] = 32'(idx[u]);
            e.tc[u]  = (idx[u] == unit_n(u) - 1);
        end
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int u = 0; u < 4; u++) begin
                check($sformatf("cnt%0d", u), obs_cnt[u], e.cnt[u]);
                check($sformatf("pos%0d", u), obs_pos[u], e.pos[u]);
                check($sformatf("tc%0d", u), 32'(obs_tc[u]), 32'(e.tc[u]));
                check($sformatf("err%0d", u), 32'(obs_err[u]), 32'd0);
            end
        end
        if (obs_tc[3]) tc_pulses++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 4; u++) idx[u] = 0;
        #1 reset = 1'b1;
        #4 check_reset("rst");
        @(negedge clk);
        reset = 1'b0;

        repeat (16) step();
        check("w8_tc_pulses", 32'(tc_pulses), 32'd2);
        check("w8_pos_width", 32'($bits(if_w8.pos)), 32'd4);

        reset = 1'b1;
        for (int u = 0; u < 4; u++) idx[u] = 0;
        #1 check_reset("rst_assert");
        repeat (5) begin
            @(posedge clk);
            #1 check_reset("rst_hold");
        end
        @(negedge clk);
        reset = 1'b0;

        step();
        step();
        check("pre_async_cnt", obs_cnt[0], 32'h4);
        #3 reset = 1'b1;
        for (int u = 0; u < 4; u++) idx[u] = 0;
        #1 check_reset("rst_async");
        @(negedge clk);
        reset = 1'b0;
        step();

        force u_def.count_q = 4'b0110;
        #1 check("err_forced", 32'(obs_err[0]), 32'd1);
        release u_def.count_q;
        @(posedge clk);
        #1;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        check("fix_cnt", obs_cnt[0], 32'h1);
        check("fix_pos", obs_pos[0], 32'd0);
        check("fix_err", 32'(obs_err[0]), 32'd0);
`else
        check("bad_cnt", obs_cnt[0], 32'hC);
        check("bad_pos", obs_pos[0], 32'((idx[0] + 1) % 4));
        check("bad_err", 32'(obs_err[0]), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ring_counter.md
Name: ring_counter

Overview:
Free-running, parameterizable shift-register counter that circulates a pattern around WIDTH flip-flops. It runs in one of two modes:
- one-hot ring mode (default)
- Johnson (twisted-ring) mode
It serves as a sequencer or phase generator for downstream logic. Beside the raw pattern it reports a binary state index, a terminal-count flag and an illegal-pattern flag.

Parameters:
- WIDTH, 4, number of flip-flops in the ring; legal range 2..32.
- JOHNSON, 0, 0 = one-hot ring (WIDTH states), 1 = Johnson counter (2*WIDTH states).
- ROTATE_LEFT, 1, 1 = shift toward MSB, 0 = shift toward LSB.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- count  output  WIDTH  current ring pattern, registered.
- pos  output  $clog2(2*WIDTH)  binary index of current state, 0..N-1; registered alongside count.
- tc  output  1  terminal count: high while the counter is in state N-1; combinational from registers.
- err  output  1  high while count holds a pattern outside the legal sequence; combinational.

Port order is fixed as listed. clk, reset and count must stay positions 1-3 so three-port positional instantiation works. There are no other inputs; the counter advances every clock.

Behaviour:
- Reset (async assert, sync-safe release):
  - Ring mode: count = 1 (only bit 0 set).
  - Johnson mode: count = 0.
  - pos = 0 in both modes.
  - While reset is high, outputs hold these values regardless of clk.
- Ring mode, ROTATE_LEFT=1, each rising edge: count <= {count[WIDTH-2:0], count[WIDTH-1]}.
  - WIDTH=4 sequence: 0001, 0010, 0100, 1000, 0001 ...
- Ring mode, ROTATE_LEFT=0: count <= {count[0], count[WIDTH-1:1]}.
  - WIDTH=4 sequence: 0001, 1000, 0100, 0010, 0001 ...
- Johnson mode, ROTATE_LEFT=1: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}.
  - WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 ...
  - ROTATE_LEFT=0 mirrors this, shifting ~count[0] in at the MSB.
- pos: N = WIDTH (ring) or 2*WIDTH (Johnson).
  - Increments by 1 each clock and wraps N-1 -> 0 in the same cycle count returns to its reset pattern.
  - pos always equals the index of count in the sequence above.
- tc: high exactly one cycle in every N, when pos == N-1.
- err:
  - Ring mode: high when count is not exactly one-hot (zero bits set or more than one bit set).
  - Johnson mode: high when count is not one of the 2*WIDTH legal patterns.
  - err is 0 in every reachable state after reset.
- Illegal state without the optional feature: the counter keeps shifting the corrupt pattern; err stays asserted; pos keeps counting.
- Reset mid-sequence: count and pos return to reset values immediately and asynchronously. The first post-release edge moves to state 1.
- Latency: count changes one clock after reset deassertion. There is no enable and no stall.

Optional Feature:
- Macro: RING_COUNTER_SELF_CORRECT_EN.
- When defined: on any rising edge where err is high, count and pos reload their reset values instead of shifting. Recovery takes exactly one clock and err clears on the next cycle.
- When undefined: no correction logic is built; behaviour is as described in Behaviour.
- Both builds must give identical results for every legal sequence.

Test Plan:
- Default params, 20 ns clock, reset high for 20 ns then low:
  - count = 0001, pos = 0 during reset.
  - After release, successive edges give 0010, 0100, 1000, 0001.
  - tc high only while count = 1000; err = 0 throughout.
- Reset held high across 5 edges -> count stays 0001, pos stays 0.
- Then assert reset asynchronously mid-cycle while count = 0100 -> count = 0001 before the next edge.
- JOHNSON=1, WIDTH=4, 10 edges after reset:
  - Sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
  - pos runs 0..7, then 0, 1.
  - tc high only at 1000.
- ROTATE_LEFT=0, ring mode -> sequence 0001, 1000, 0100, 0010, 0001; tc at 0010.
- Force count to 0110 (ring mode) via bench force/release:
  - err = 1 immediately.
  - With RING_COUNTER_SELF_CORRECT_EN: next edge count = 0001, pos = 0, err = 0.
  - Without it: count becomes 1100 and err stays 1.
- WIDTH=8, ring mode, 16 edges -> one-hot bit walks 0..7 twice; tc pulses exactly twice; pos width 4 bits.
